// File: rtl/sy_ppl_fl_mw.sv
// Multi-way physical register free list: all-or-nothing allocation of up to
// ALLOC_PORTS registers per cycle, ROB-driven release, and flush restore from the architectural list.
module sy_ppl_fl_mw #(
    parameter int PHY_REG_NUM  = 64,
    parameter int ARC_REG_NUM  = 32,
    parameter int ALLOC_PORTS  = 2,
    parameter int RETIRE_PORTS = 2,
    parameter int PHY_REG_WTH  = $clog2(PHY_REG_NUM)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [ALLOC_PORTS-1:0]                    rdst_en_i,
    input  logic [ALLOC_PORTS-1:0][4:0]               arc_rdst_idx_i,
    output logic [ALLOC_PORTS-1:0][PHY_REG_WTH-1:0]   phy_rdst_idx_o,
    output logic                                      fl_stall_o,
    output logic [PHY_REG_WTH:0]                      free_cnt_o,
    input  logic [RETIRE_PORTS-1:0]                   rob_update_afl_en_i,
    input  logic [RETIRE_PORTS-1:0][PHY_REG_WTH-1:0]  rob_update_afl_phy_i,
    input  logic [RETIRE_PORTS-1:0][PHY_REG_WTH-1:0]  rob_update_afl_old_phy_i
);

    function automatic logic [PHY_REG_NUM-1:0] reset_map();
        logic [PHY_REG_NUM-1:0] m;
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            m[i] = (i >= ARC_REG_NUM);
        end
        return m;
    endfunction

    localparam logic [PHY_REG_NUM-1:0] RESET_MAP = reset_map();

    logic [PHY_REG_NUM-1:0]                  free_list_r;
    logic [PHY_REG_NUM-1:0]                  arc_free_list_r;
    logic [PHY_REG_NUM-1:0]                  free_list_nxt_s;
    logic [PHY_REG_NUM-1:0]                  arc_free_list_nxt_s;
    logic [ALLOC_PORTS-1:0]                  need_s;
    logic [ALLOC_PORTS-1:0][PHY_REG_WTH-1:0] sel_s;
    logic [PHY_REG_WTH:0]                    need_cnt_s;
    logic [PHY_REG_WTH:0]                    free_cnt_s;
    logic                                    stall_s;

    // Ports writing x0 or idle get no register.
    always_comb begin
        for (int p = 0; p < ALLOC_PORTS; p++) begin
            need_s[p] = rdst_en_i[p] && (arc_rdst_idx_i[p] != 5'd0);
        end
    end

    // Population count of the speculative list, reg 0 excluded.
    always_comb begin
        free_cnt_s = '0;
        for (int i = 1; i < PHY_REG_NUM; i++) begin
            free_cnt_s = free_cnt_s + {{PHY_REG_WTH{1'b0}}, free_list_r[i]};
        end
    end

    // Needing ports take successive lowest free bits; each pick is masked out for later ports.
    always_comb begin
        logic [PHY_REG_NUM-1:0] avail;
        logic [PHY_REG_NUM-1:0] cand;
        avail      = free_list_r;
        avail[0]   = 1'b0;
        cand       = '0;
        need_cnt_s = '0;
        for (int p = 0; p < ALLOC_PORTS; p++) begin
            cand     = need_s[p] ? avail : '0;
            sel_s[p] = '0;
            for (int i = PHY_REG_NUM - 1; i >= 1; i--) begin
                sel_s[p] = cand[i] ? PHY_REG_WTH'(i) : sel_s[p];
            end
            avail[sel_s[p]] = 1'b0;
            need_cnt_s      = need_cnt_s + (PHY_REG_WTH + 1)'(need_s[p]);
        end
    end

    assign stall_s = (need_cnt_s > free_cnt_s);

    // Next architectural list: later retire ports override earlier ones on shared bits.
    always_comb begin
        arc_free_list_nxt_s = arc_free_list_r;
        for (int r = 0; r < RETIRE_PORTS; r++) begin
            arc_free_list_nxt_s[rob_update_afl_old_phy_i[r]] =
                arc_free_list_nxt_s[rob_update_afl_old_phy_i[r]] | rob_update_afl_en_i[r];
            arc_free_list_nxt_s[rob_update_afl_phy_i[r]] =
                arc_free_list_nxt_s[rob_update_afl_phy_i[r]] & ~rob_update_afl_en_i[r];
        end
        arc_free_list_nxt_s[0] = 1'b0;
    end

    // Next speculative list: flush restores from the updated architectural list.
    always_comb begin
        free_list_nxt_s = free_list_r;
        for (int p = 0; p < ALLOC_PORTS; p++) begin
            free_list_nxt_s[sel_s[p]] = free_list_nxt_s[sel_s[p]] & ~(need_s[p] & ~stall_s);
        end
        for (int r = 0; r < RETIRE_PORTS; r++) begin
            free_list_nxt_s[rob_update_afl_old_phy_i[r]] =
                free_list_nxt_s[rob_update_afl_old_phy_i[r]] | rob_update_afl_en_i[r];
        end
        if (flush_i) begin
            free_list_nxt_s = arc_free_list_nxt_s;
        end else begin
            free_list_nxt_s[0] = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_list_r     <= RESET_MAP;
            arc_free_list_r <= RESET_MAP;
        end else begin
            free_list_r     <= free_list_nxt_s;
            arc_free_list_r <= arc_free_list_nxt_s;
        end
    end

    assign phy_rdst_idx_o = sel_s;
    assign fl_stall_o     = stall_s;
    assign free_cnt_o     = free_cnt_s;

    sy_ppl_fl_mw_chk #(
        .PHY_REG_NUM  (PHY_REG_NUM),
        .RETIRE_PORTS (RETIRE_PORTS),
        .PHY_REG_WTH  (PHY_REG_WTH)
    ) u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (rob_update_afl_en_i),
        .phy_i     (rob_update_afl_phy_i),
        .old_phy_i (rob_update_afl_old_phy_i),
        .free_list (free_list_r)
    );

endmodule

// Illegal retire-port usage checks.
module sy_ppl_fl_mw_chk #(
    parameter int PHY_REG_NUM  = 64,
    parameter int RETIRE_PORTS = 2,
    parameter int PHY_REG_WTH  = 6
) (
    input logic                                     clk_i,
    input logic                                     rst_i,
    input logic [RETIRE_PORTS-1:0]                  en_i,
    input logic [RETIRE_PORTS-1:0][PHY_REG_WTH-1:0] phy_i,
    input logic [RETIRE_PORTS-1:0][PHY_REG_WTH-1:0] old_phy_i,
    input logic [PHY_REG_NUM-1:0]                   free_list
);
    for (genvar r = 0; r < RETIRE_PORTS; r++) begin : g_port
        a_nonzero : assert property (@(posedge clk_i) disable iff (rst_i)
            en_i[r] |-> (phy_i[r] != '0) && (old_phy_i[r] != '0));
        a_not_free : assert property (@(posedge clk_i) disable iff (rst_i)
            en_i[r] |-> !free_list[old_phy_i[r]]);
        for (genvar q = r + 1; q < RETIRE_PORTS; q++) begin : g_pair
            a_distinct : assert property (@(posedge clk_i) disable iff (rst_i)
                (en_i[r] && en_i[q]) |-> (old_phy_i[r] != old_phy_i[q]));
        end
    end
endmodule

// File: tb/tb_sy_ppl_fl_mw.sv
// Self-checking bench for sy_ppl_fl_mw: directed vector table, hand-written
// corner sequences and randomized traffic against a set-based reference model.
module tb_sy_ppl_fl_mw;
    localparam int PN = 64;
    localparam int AN = 32;
    localparam int X  = -1;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [1:0]      en;
    logic [1:0][4:0] rd;
    logic [1:0][5:0] pidx;
    logic            stall;
    logic [6:0]      cnt;
    logic [1:0]      ren;
    logic [1:0][5:0] rphy, rold;

    always #5 clk = ~clk;

    sy_ppl_fl_mw dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .flush_i                  (flush),
        .rdst_en_i                (en),
        .arc_rdst_idx_i           (rd),
        .phy_rdst_idx_o           (pidx),
        .fl_stall_o               (stall),
        .free_cnt_o               (cnt),
        .rob_update_afl_en_i      (ren),
        .rob_update_afl_phy_i     (rphy),
        .rob_update_afl_old_phy_i (rold)
    );

    typedef struct {
        bit rst; bit flush; bit [1:0] en; int rd0; int rd1;
        bit [1:0] ren; int phy0; int old0; int phy1; int old1;
        int e0; int e1; int es; int ec;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit mfree[PN];
    bit marc[PN];
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit [1:0] e, int a0, int a1, bit [1:0] re,
                                int p0, int o0, int p1, int o1,
                                int e0, int e1, int es, int ec);
        vec_t v;
        v.rst = r; v.flush = f; v.en = e; v.rd0 = a0; v.rd1 = a1;
        v.ren = re; v.phy0 = p0; v.old0 = o0; v.phy1 = p1; v.old1 = o1;
        v.e0 = e0; v.e1 = e1; v.es = es; v.ec = ec;
        return v;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 1; i < PN; i++) c += int'(mfree[i]);
        return c;
    endfunction

    // Needing ports take the lowest free registers in port order.
    task automatic model_predict(input vec_t v, output int s0, output int s1, output int st);
        bit n0 = v.en[0] && (v.rd0 != 0);
        bit n1 = v.en[1] && (v.rd1 != 0);
        st = ((int'(n0) + int'(n1)) > model_cnt()) ? 1 : 0;
        s0 = 0; s1 = 0;
        for (int i = 1; i < PN; i++) begin
            if (mfree[i]) begin
                if (n0 && s0 == 0) s0 = i;
                else if (n1 && s1 == 0) s1 = i;
            end
        end
    endtask

    task automatic model_commit(input vec_t v, input int s0, input int s1, input int st);
        bit n0 = v.en[0] && (v.rd0 != 0);
        bit n1 = v.en[1] && (v.rd1 != 0);
        if (v.rst) begin
            for (int i = 0; i < PN; i++) begin
                mfree[i] = (i >= AN);
                marc[i]  = (i >= AN);
            end
        end else begin
            if (v.ren[0]) begin marc[v.old0] = 1'b1; marc[v.phy0] = 1'b0; end
            if (v.ren[1]) begin marc[v.old1] = 1'b1; marc[v.phy1] = 1'b0; end
            marc[0] = 1'b0;
            if (v.flush) begin
                for (int i = 0; i < PN; i++) mfree[i] = marc[i];
            end else begin
                if (st == 0 && n0) mfree[s0] = 1'b0;
                if (st == 0 && n1) mfree[s1] = 1'b0;
                if (v.ren[0]) mfree[v.old0] = 1'b1;
                if (v.ren[1]) mfree[v.old1] = 1'b1;
                mfree[0] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        if (exp >= 0) begin
            n_checks++;
            if (act != exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
            end
        end
    endtask

    task automatic step(input vec_t v);
        int s0, s1, st;
        rst = v.rst; flush = v.flush; en = v.en;
        rd[0] = v.rd0[4:0]; rd[1] = v.rd1[4:0];
        ren = v.ren;
        rphy[0] = v.phy0[5:0]; rold[0] = v.old0[5:0];
        rphy[1] = v.phy1[5:0]; rold[1] = v.old1[5:0];
        model_predict(v, s0, s1, st);
        #1;
        check("stall", int'(stall), v.es);
        check("idx0", int'(pidx[0]), v.e0);
        check("idx1", int'(pidx[1]), v.e1);
        check("free_cnt", int'(cnt), v.ec);
        @(posedge clk);
        model_commit(v, s0, s1, st);
        #1;
    endtask

    initial begin
        vec_t v;
        int s0, s1, st;
        int q[$];
        int k;
        rst = 1'b1; flush = 1'b0; en = '0; rd = '0; ren = '0; rphy = '0; rold = '0;

        // Reset values and basic two-port allocation
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,32));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 32,33,0,32));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,30));
        // x0 bypass
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        tbl.push_back(mk(0,0,3,0,5,0,0,0,0,0, 0,32,0,32));
        tbl.push_back(mk(0,0,1,3,0,0,0,0,0,0, 33,0,0,31));
        // Flush with same-cycle retire
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 32,33,0,32));
        tbl.push_back(mk(0,0,3,3,4,0,0,0,0,0, 34,35,0,30));
        tbl.push_back(mk(0,1,0,0,0,1,32,1,0,0, 0,0,0,28));
        tbl.push_back(mk(0,0,1,5,0,0,0,0,0,0, 1,0,0,32));
        tbl.push_back(mk(0,0,1,6,0,0,0,0,0,0, 33,0,0,31));
        // Retire ordering on the architectural list
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 32,33,0,32));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 34,35,0,30));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 36,37,0,28));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 38,39,0,26));
        tbl.push_back(mk(0,0,1,7,0,0,0,0,0,0, 40,0,0,24));
        tbl.push_back(mk(0,0,0,0,0,3,40,3,41,40, 0,0,0,23));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,25));
        tbl.push_back(mk(0,0,3,1,2,0,0,0,0,0, 3,32,0,32));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Drain to a single free register, then all-or-nothing stall
        step(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        for (int i = 0; i < 15; i++)
            step(mk(0,0,3,1,2,0,0,0,0,0, 32+2*i,33+2*i,0,32-2*i));
        step(mk(0,0,1,1,0,0,0,0,0,0, 62,0,0,2));
        step(mk(0,0,3,1,2,0,0,0,0,0, X,X,1,1));
        step(mk(0,0,1,1,0,0,0,0,0,0, 63,0,0,1));
        step(mk(0,0,3,0,0,0,0,0,0,0, 0,0,0,0));
        step(mk(0,0,1,4,0,0,0,0,0,0, X,X,1,0));
        // Release then reuse in the next cycle
        step(mk(0,0,0,0,0,1,50,7,0,0, 0,0,0,0));
        step(mk(0,0,1,9,0,0,0,0,0,0, 7,0,0,1));
        step(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

        // Randomized traffic against the reference model
        step(mk(1,0,0,0,0,0,0,0,0,0, X,X,X,X));
        for (int n = 0; n < 600; n++) begin
            v = mk(0, ($urandom_range(15) == 0), 2'($urandom), int'($urandom_range(31)),
                   int'($urandom_range(31)), 2'($urandom), int'($urandom_range(63, 1)), 0,
                   int'($urandom_range(63, 1)), 0, 0, 0, 0, 0);
            q.delete();
            for (int i = 1; i < PN; i++) if (!mfree[i]) q.push_back(i);
            if (v.ren[0] && q.size() > 0) begin
                k = int'($urandom_range(q.size() - 1));
                v.old0 = q[k]; q.delete(k);
            end else v.ren[0] = 1'b0;
            if (v.ren[1] && q.size() > 0) begin
                k = int'($urandom_range(q.size() - 1));
                v.old1 = q[k]; q.delete(k);
            end else v.ren[1] = 1'b0;
            model_predict(v, s0, s1, st);
            v.es = st;
            v.ec = model_cnt();
            v.e0 = (st != 0) ? X : s0;
            v.e1 = (st != 0) ? X : s1;
            step(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
